enet_bus_arbiter: RTL and testbench
===================================

# enet_bus_arbiter

Arbitrates access to the shared DM9000A Ethernet controller command port among N requesters (init sequencer, TX engine, RX engine, host-register path). It grants one requester at a time and muxes the owner's command fields onto the controller. On release, it does not re-arbitrate until the controller reports ready. It sits between the requester FSMs and the low-level DM9000A bus-cycle controller.

## Interface
- N, 3: number of requesters, 2..8; index 0 is the init sequencer.
- IDXW, 2: width of owner index; must be ≥ clog2(N).
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- req_in  in  N  per-requester access request, level, held for the whole transaction.
- addr_in  in  8*N  register address, requester i at [8i+7:8i].
- dataw_in  in  16*N  write data, requester i at [16i+15:16i].
- delay_in  in  3*N  post-command delay code, requester i at [3i+2:3i].
- start_comm_in  in  N  one-cycle command strobe per requester.
- enet_controller_rdy_in  in  1  controller idle and able to accept a command.
- grant_out  out  N  one-hot grant, registered.
- enet_addr_out  out  8  owner's addr.
- enet_dataw_out  out  16  owner's dataw.
- enet_delay_out  out  3  owner's delay code.
- enet_start_comm_out  out  1  owner's start strobe, gated by grant.
- owner_out  out  IDXW  index of current or last owner, registered.
- busy_out  out  1  high in GRANTED and RELEASE.

## Operation
- States:
  - IDLE: if `req_in != 0`, select a winner, load `owner`, set its grant bit, and go to GRANTED. Otherwise stay in IDLE.
  - GRANTED: hold the grant while `req_in[owner]` is high. When it drops, clear `grant_out` and go to RELEASE.
  - RELEASE: wait for `enet_controller_rdy_in` = 1, then go to IDLE. Requests are not sampled here.
- Selection, fixed priority (default): the lowest set index wins.
- Muxing:
  - When `grant_out[owner]` = 1, the `enet_*` outputs equal the owner's fields.
  - Otherwise `addr`/`dataw`/`delay`/`start` are all 0.
  - `start_comm_in` from any non-granted requester is ignored and never reaches the controller.
- Non-owners may keep `req_in` high indefinitely. They wait with no starvation guarantee in fixed-priority mode.
- The arbiter does not pre-empt. The owner holds the bus across any number of commands.

## Timing
- Reset values:
  - state = IDLE.
  - `grant_out` = 0.
  - `owner_out` = N-1.
  - `busy_out` = 0.
  - all `enet_*` outputs = 0.
- Reset asserted mid-transaction drops the grant at the next edge, regardless of `enet_controller_rdy_in`.
- Grant latency: a request sampled at edge k in IDLE gives `grant_out` high after edge k. The minimum is 1 cycle from `req_in` rising.
- Release:
  - `req_in[owner]` low at edge k gives grant low after edge k.
  - With rdy high at edge k+1, the state is IDLE after k+1.
  - The earliest next grant is after edge k+2. The minimum gap between grants is 2 cycles.
- A requester that drops and re-raises req within RELEASE is treated as a fresh request in IDLE.
- Simultaneous requests in IDLE are resolved by the selection rule in the same cycle. Exactly one grant bit is ever set.
- `enet_*` outputs are combinational from the registered grant/owner and the `*_in` buses. There is no added latency.
- A `start_comm_in` asserted in the same cycle the grant clears is dropped.

## Configuration
- `ENET_ARB_RR_EN`, defined: round-robin selection.
  - The search starts at `owner_out+1` (mod N) and the first set request wins.
  - After reset, requester 0 has top priority, because `owner_out` resets to N-1.
- `ENET_ARB_RR_EN`, undefined: fixed priority, lowest index wins. `owner_out` is still updated on each grant.

## Test plan
- Reset with `req_in`=3'b111, then release reset → `grant_out`=3'b001 one cycle later, `owner_out`=0, `busy_out`=1.
- Owner 0 pulses `start_comm_in[0]` with addr 8'hFE, data 16'h00_3F while requester 1 pulses `start_comm_in[1]` → controller sees exactly one strobe, addr FE, data 003F.
- Owner drops req while rdy=0 for 5 cycles → grant low after 1 cycle, `busy_out` high for 5 more cycles, IDLE one cycle after rdy rises, next grant one cycle later.
- `req_in`=3'b110 held, owner 1 releases and re-requests repeatedly → without RR, grants alternate with 1 always winning; with `ENET_ARB_RR_EN`, grants alternate 1,2,1,2.
- Reset asserted during GRANTED with rdy=0 → `grant_out`=0, `busy_out`=0, `enet_start_comm_out`=0 after that edge.
- N=4, all requests high, RR enabled, each owner holds 3 cycles → grant order 0,1,2,3,0 with 2-cycle gaps and no two grant bits ever high together.

Source files
------------

// File: rtl/enet_bus_arbiter.sv
// ============================================================================
// Module   : enet_bus_arbiter
// Purpose  : Grants the shared DM9000A command port to one requester at a time
//            and muxes the owner's command fields onto the controller.
//            Define ENET_ARB_RR_EN for round-robin selection (default: fixed
//            priority, lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enet_bus_arbiter #(
  parameter int N    = 3,
  parameter int IDXW = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N-1:0]    req_in,
  input  logic [8*N-1:0]  addr_in,
  input  logic [16*N-1:0] dataw_in,
  input  logic [3*N-1:0]  delay_in,
  input  logic [N-1:0]    start_comm_in,
  input  logic            enet_controller_rdy_in,
  output logic [N-1:0]    grant_out,
  output logic [7:0]      enet_addr_out,
  output logic [15:0]     enet_dataw_out,
  output logic [2:0]      enet_delay_out,
  output logic            enet_start_comm_out,
  output logic [IDXW-1:0] owner_out,
  output logic            busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] c_OWNER_RST = IDXW'(N - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    w_grant_nxt;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] w_owner_nxt;
  logic [IDXW-1:0] w_winner;
  logic            w_owner_req;

`ifdef ENET_ARB_RR_EN
  // Search starts just past the last owner, so the previous owner ranks last.
  always_comb begin : p_select
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_owner) + k) % N;
      if (!found && req_in[idx]) begin
        w_winner = IDXW'(idx);
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin : p_select
    w_winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) w_winner = IDXW'(i);
    end
  end
`endif

  // The grant is one-hot on the owner, so this picks req_in[owner].
  assign w_owner_req = |(req_in & r_grant);

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (|req_in) begin
          w_owner_nxt = w_winner;
          w_grant_nxt = N'(1) << w_winner;
          w_state_nxt = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!w_owner_req) begin
          w_grant_nxt = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (enet_controller_rdy_in) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin : p_state
    if (Reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= c_OWNER_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // AND-OR mux on the one-hot grant; all zero whenever no grant is held.
  always_comb begin : p_mux
    enet_addr_out  = '0;
    enet_dataw_out = '0;
    enet_delay_out = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        enet_addr_out  = enet_addr_out  | addr_in[8*i +: 8];
        enet_dataw_out = enet_dataw_out | dataw_in[16*i +: 16];
        enet_delay_out = enet_delay_out | delay_in[3*i +: 3];
      end
    end
  end

  assign enet_start_comm_out = |(start_comm_in & r_grant);
  assign grant_out           = r_grant;
  assign owner_out           = r_owner;
  assign busy_out            = (r_state == ST_GRANTED) || (r_state == ST_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_enet_bus_arbiter.sv
// ============================================================================
// Module   : tb_enet_bus_arbiter
// Purpose  : Self-checking bench for enet_bus_arbiter against a behavioural
//            model; honours ENET_ARB_RR_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enet_bus_arbiter;

  localparam int N    = 3;
  localparam int IDXW = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    req_in = '0;
  logic [8*N-1:0]  addr_in = '0;
  logic [16*N-1:0] dataw_in = '0;
  logic [3*N-1:0]  delay_in = '0;
  logic [N-1:0]    start_comm_in = '0;
  logic            enet_controller_rdy_in = 1'b1;
  logic [N-1:0]    grant_out;
  logic [7:0]      enet_addr_out;
  logic [15:0]     enet_dataw_out;
  logic [2:0]      enet_delay_out;
  logic            enet_start_comm_out;
  logic [IDXW-1:0] owner_out;
  logic            busy_out;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = free, 1 = held, 2 = waiting on controller.
  int           m_phase = 0;
  int           m_owner = N - 1;
  logic [N-1:0] m_grant = '0;

  enet_bus_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .Clock                  (Clock),
    .Reset                  (Reset),
    .req_in                 (req_in),
    .addr_in                (addr_in),
    .dataw_in               (dataw_in),
    .delay_in               (delay_in),
    .start_comm_in          (start_comm_in),
    .enet_controller_rdy_in (enet_controller_rdy_in),
    .grant_out              (grant_out),
    .enet_addr_out          (enet_addr_out),
    .enet_dataw_out         (enet_dataw_out),
    .enet_delay_out         (enet_delay_out),
    .enet_start_comm_out    (enet_start_comm_out),
    .owner_out              (owner_out),
    .busy_out               (busy_out)
  );

  always #5 Clock = ~Clock;

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef ENET_ARB_RR_EN
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return 0;
  endfunction

  function automatic logic [7:0] e_addr();
    return (m_grant != 0) ? addr_in[8*m_owner +: 8] : 8'h00;
  endfunction
  function automatic logic [15:0] e_dataw();
    return (m_grant != 0) ? dataw_in[16*m_owner +: 16] : 16'h0000;
  endfunction
  function automatic logic [2:0] e_delay();
    return (m_grant != 0) ? delay_in[3*m_owner +: 3] : 3'b000;
  endfunction
  function automatic logic e_start();
    return (m_grant != 0) ? start_comm_in[m_owner] : 1'b0;
  endfunction

  // Advance one clock, stepping the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge Clock);
    if (Reset) begin
      m_phase = 0; m_grant = '0; m_owner = N - 1;
    end else begin
      case (m_phase)
        0: if (req_in != 0) begin
             m_owner = pick(req_in, m_owner);
             m_grant = N'(1) << m_owner;
             m_phase = 1;
           end
        1: if (!req_in[m_owner]) begin
             m_grant = '0;
             m_phase = 2;
           end
        default: if (enet_controller_rdy_in) m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; req_in = 3'b111; start_comm_in = 3'b111;
    addr_in = {8'h33, 8'h22, 8'h11};
    tick(); tick();
    checks++; if (grant_out !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant_out); end
    checks++; if (owner_out !== 2'd2) begin errors++; $display("FAIL reset_owner: got %0d expected 2", owner_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    checks++; if (enet_addr_out !== 8'h00 || enet_start_comm_out !== 1'b0) begin
      errors++; $display("FAIL reset_enet: got addr %h start %b expected 00/0", enet_addr_out, enet_start_comm_out); end
    start_comm_in = '0;
    Reset = 1'b0;
    tick();
    checks++; if (grant_out !== 3'b001) begin errors++; $display("FAIL first_grant: got %b expected 001", grant_out); end
    checks++; if (owner_out !== 2'd0) begin errors++; $display("FAIL first_owner: got %0d expected 0", owner_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy_out); end
  endtask

  task automatic test_mux();
    addr_in[7:0] = 8'hFE; dataw_in[15:0] = 16'h003F; delay_in[2:0] = 3'd5;
    addr_in[15:8] = 8'h11; dataw_in[31:16] = 16'hAAAA; delay_in[5:3] = 3'd2;
    start_comm_in = 3'b011;
    #1;
    checks++; if (enet_addr_out !== 8'hFE || enet_dataw_out !== 16'h003F || enet_delay_out !== 3'd5) begin
      errors++; $display("FAIL mux_fields: got %h/%h/%0d expected FE/003F/5", enet_addr_out, enet_dataw_out, enet_delay_out); end
    checks++; if (enet_start_comm_out !== 1'b1) begin errors++; $display("FAIL mux_owner_start: got %b expected 1", enet_start_comm_out); end
    tick();
    start_comm_in = 3'b010;
    #1;
    checks++; if (enet_start_comm_out !== 1'b0) begin errors++; $display("FAIL mux_nonowner_start: got %b expected 0", enet_start_comm_out); end
    start_comm_in = '0;
    tick();
  endtask

  task automatic test_release();
    req_in = 3'b001; tick();
    enet_controller_rdy_in = 1'b0;
    req_in = 3'b000; start_comm_in = 3'b001;
    tick();
    checks++; if (grant_out !== 3'b000 || busy_out !== 1'b1) begin
      errors++; $display("FAIL release_drop: got grant %b busy %b expected 000/1", grant_out, busy_out); end
    checks++; if (enet_start_comm_out !== 1'b0) begin errors++; $display("FAIL release_start_dropped: got %b expected 0", enet_start_comm_out); end
    start_comm_in = '0;
    req_in = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (busy_out !== 1'b1 || grant_out !== 3'b000) begin
        errors++; $display("FAIL release_wait%0d: got busy %b grant %b expected 1/000", i, busy_out, grant_out); end
    end
    enet_controller_rdy_in = 1'b1;
    tick();
    checks++; if (busy_out !== 1'b0 || grant_out !== 3'b000) begin
      errors++; $display("FAIL release_idle: got busy %b grant %b expected 0/000", busy_out, grant_out); end
    tick();
    checks++; if (grant_out !== 3'b001 || busy_out !== 1'b1) begin
      errors++; $display("FAIL release_regrant: got grant %b busy %b expected 001/1", grant_out, busy_out); end
  endtask

  task automatic test_alternate();
    int exp_own[4];
`ifdef ENET_ARB_RR_EN
    exp_own = '{1, 2, 1, 2};
`else
    exp_own = '{1, 1, 1, 1};
`endif
    Reset = 1'b1; req_in = '0; tick();
    Reset = 1'b0; enet_controller_rdy_in = 1'b1; req_in = 3'b110;
    tick();
    for (int r = 0; r < 4; r++) begin
      checks++; if (owner_out !== IDXW'(exp_own[r]) || grant_out !== (N'(1) << exp_own[r])) begin
        errors++; $display("FAIL alternate_round%0d: got owner %0d grant %b expected owner %0d", r, owner_out, grant_out, exp_own[r]); end
      req_in = 3'b110 & ~(N'(1) << exp_own[r]);
      tick();
      req_in = 3'b110;
      tick(); tick();
    end
  endtask

  task automatic test_reset_mid();
    enet_controller_rdy_in = 1'b0; start_comm_in = 3'b111; req_in = 3'b110;
    #1;
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b expected 1", busy_out); end
    Reset = 1'b1;
    tick();
    checks++; if (grant_out !== 3'b000 || busy_out !== 1'b0 || enet_start_comm_out !== 1'b0) begin
      errors++; $display("FAIL midreset: got grant %b busy %b start %b expected 000/0/0", grant_out, busy_out, enet_start_comm_out); end
    checks++; if (owner_out !== 2'd2) begin errors++; $display("FAIL midreset_owner: got %0d expected 2", owner_out); end
    Reset = 1'b0; req_in = '0; start_comm_in = '0; enet_controller_rdy_in = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) req_in[i] = ~req_in[i];
      enet_controller_rdy_in = ($urandom_range(2) != 0);
      start_comm_in = N'($urandom);
      addr_in = (8*N)'({$urandom, $urandom});
      dataw_in = (16*N)'({$urandom, $urandom});
      delay_in = (3*N)'($urandom);
      Reset = ($urandom_range(99) == 0);
      tick();
      checks++; if (grant_out !== m_grant) begin errors++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, grant_out, m_grant); end
      checks++; if (owner_out !== IDXW'(m_owner)) begin errors++; $display("FAIL rnd_owner c%0d: got %0d expected %0d", c, owner_out, m_owner); end
      checks++; if (busy_out !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy_out, m_phase != 0); end
      checks++; if (enet_addr_out !== e_addr() || enet_dataw_out !== e_dataw() || enet_delay_out !== e_delay()) begin
        errors++; $display("FAIL rnd_fields c%0d: got %h/%h/%0d expected %h/%h/%0d", c,
          enet_addr_out, enet_dataw_out, enet_delay_out, e_addr(), e_dataw(), e_delay()); end
      checks++; if (enet_start_comm_out !== e_start()) begin errors++; $display("FAIL rnd_start c%0d: got %b expected %b", c, enet_start_comm_out, e_start()); end
      checks++; if ($countones(grant_out) > 1) begin errors++; $display("FAIL rnd_onehot c%0d: got %b expected at most one bit", c, grant_out); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mux();
    test_release();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
